div_sequencer: RTL and testbench

Sequencer and arbiter for the shared restoring-division datapath. Two requesters share one divider. The block grants the datapath to one of them in round-robin order and drives the per-cycle datapath controls (load, add, shift, inbit, sel) for a fixed number of iterations. It then pulses a per-requester done. It sits between the client request logic and the divider datapath, and it also owns the iteration count.

---
 rtl/div_pkg.sv | 57 +++++
 rtl/rr_arb2.sv | 43 ++++
 rtl/div_sequencer.sv | 122 ++++++++++++
 tb/tb_div_sequencer.sv | 239 +++++++++++++++++++++++
 4 files changed

// File: rtl/div_pkg.sv
// Shared types and encodings for the restoring-division sequencer and its arbiter.
package div_pkg;

  localparam int NREQ = 2;

  typedef enum logic [2:0] {
    ST_IDLE    = 3'd0,
    ST_LOAD    = 3'd1,
    ST_TEST    = 3'd2,
    ST_RESTORE = 3'd3,
    ST_ACCEPT  = 3'd4,
    ST_DONE    = 3'd5
  } state_e;

  localparam logic [1:0] SEL_NONE   = 2'b00;
  localparam logic [1:0] SEL_HOLD   = 2'b01;
  localparam logic [1:0] SEL_LOAD   = 2'b10;
  localparam logic [1:0] SEL_SHIFT1 = 2'b11;

  typedef struct packed {
    logic       load;
    logic       add;
    logic       shift;
    logic       inbit;
    logic [1:0] sel;
  } ctrl_t;

  // Datapath controls are a pure function of state (Moore).
  function automatic ctrl_t ctrl_decode(input state_e st);
    ctrl_t c;
    c = '0;
    c.sel = SEL_NONE;
    case (st)
      ST_LOAD: begin
        c.load  = 1'b1;
        c.shift = 1'b1;
        c.sel   = SEL_LOAD;
      end
      ST_TEST: begin
        c.sel   = SEL_HOLD;
      end
      ST_RESTORE: begin
        c.add   = 1'b1;
        c.shift = 1'b1;
        c.sel   = SEL_HOLD;
      end
      ST_ACCEPT: begin
        c.shift = 1'b1;
        c.inbit = 1'b1;
        c.sel   = SEL_SHIFT1;
      end
      default: c = '0;
    endcase
    return c;
  endfunction

endpackage

// File: rtl/rr_arb2.sv
// Two-way round-robin arbiter; ptr_q names the requester that wins the next tie.
module rr_arb2
  import div_pkg::*;
(
  input  logic            clk,
  input  logic            reset,
  input  logic [NREQ-1:0] req_i,
  input  logic            update_i,
  output logic [NREQ-1:0] winner_o,
  output logic            ptr_o
);

  logic ptr_q, ptr_d;

  always_comb begin
    winner_o = '0;
    case (req_i)
      2'b01:   winner_o = 2'b01;
      2'b10:   winner_o = 2'b10;
      2'b11:   winner_o = ptr_q ? 2'b10 : 2'b01;
      default: winner_o = '0;
    endcase
  end

  // After a grant the other requester becomes favoured, single grants included.
  always_comb begin
    ptr_d = ptr_q;
    if (update_i && (|req_i)) begin
      ptr_d = winner_o[0];
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      ptr_q <= 1'b0;
    end else begin
      ptr_q <= ptr_d;
    end
  end

  assign ptr_o = ptr_q;

endmodule

// File: rtl/div_sequencer.sv
// Arbitrates two requesters onto one restoring divider and sequences its
// load/test/restore/accept iterations, pulsing done to the owner at the end.
module div_sequencer
  import div_pkg::*;
#(
  parameter int WIDTH = 8
) (
  input  logic            clk,
  input  logic            reset,
  input  logic [NREQ-1:0] req,
  input  logic            sign,
  output logic [NREQ-1:0] grant,
  output logic [NREQ-1:0] done,
  output logic            busy,
  output logic            load,
  output logic            add,
  output logic            shift,
  output logic            inbit,
  output logic [1:0]      sel
);

  localparam int CNT_W = (WIDTH > 1) ? $clog2(WIDTH) : 1;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(WIDTH - 1);

  state_e          state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [NREQ-1:0] grant_q, grant_d;
  logic [NREQ-1:0] arb_req;
  logic [NREQ-1:0] arb_win;
  logic            arb_ptr;
  logic            start;
  ctrl_t           ctrl;

  // Requests only count in IDLE and DONE; in DONE the owner is masked so a
  // requester holding req high cannot starve the other one.
  always_comb begin
    arb_req = '0;
    if (state_q == ST_IDLE) begin
      arb_req = req;
    end else if (state_q == ST_DONE) begin
      arb_req = req & ~grant_q;
    end
  end

  assign start = |arb_req;

  rr_arb2 u_arb (
    .clk      (clk),
    .reset    (reset),
    .req_i    (arb_req),
    .update_i (start),
    .winner_o (arb_win),
    .ptr_o    (arb_ptr)
  );

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    grant_d = grant_q;
    case (state_q)
      ST_IDLE, ST_DONE: begin
        if (start) begin
          state_d = ST_LOAD;
          grant_d = arb_win;
        end else begin
          state_d = ST_IDLE;
          grant_d = '0;
        end
      end
      ST_LOAD: begin
        state_d = ST_TEST;
        cnt_d   = '0;
      end
      ST_TEST: begin
        state_d = sign ? ST_RESTORE : ST_ACCEPT;
      end
      ST_RESTORE, ST_ACCEPT: begin
        // The last iteration leaves cnt at WIDTH-1 so it never wraps.
        if (cnt_q == CNT_LAST) begin
          state_d = ST_DONE;
        end else begin
          state_d = ST_TEST;
          cnt_d   = cnt_q + CNT_W'(1);
        end
      end
      default: begin
        state_d = ST_IDLE;
        grant_d = '0;
      end
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q <= ST_IDLE;
      cnt_q   <= '0;
      grant_q <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      grant_q <= grant_d;
    end
  end

  assign ctrl  = ctrl_decode(state_q);
  assign load  = ctrl.load;
  assign add   = ctrl.add;
  assign shift = ctrl.shift;
  assign inbit = ctrl.inbit;
  assign sel   = ctrl.sel;

  assign grant = grant_q;
  assign done  = (state_q == ST_DONE) ? grant_q : '0;
  assign busy  = (state_q != ST_IDLE);

`ifndef SYNTHESIS
  a_grant_onehot: assert property (@(posedge clk) disable iff (!reset) $onehot0(grant_q));
  a_ptr_tracks: assert property (@(posedge clk) disable iff (!reset)
    (state_q == ST_LOAD) |-> (arb_ptr == grant_q[0]));
`endif

endmodule

// File: tb/tb_div_sequencer.sv
// Randomized and directed bench for div_sequencer against an operation-level model.
module tb_div_sequencer;

  localparam int W    = 8;
  localparam int LAST = 2 * W + 1;

  localparam logic [5:0] C_IDLE = 6'b000000;
  localparam logic [5:0] C_LOAD = 6'b101010;
  localparam logic [5:0] C_TEST = 6'b000001;
  localparam logic [5:0] C_REST = 6'b011001;
  localparam logic [5:0] C_ACC  = 6'b001111;

  logic       clk = 1'b0;
  logic       reset;
  logic [1:0] req;
  logic       sign;
  logic [1:0] grant, done, sel;
  logic       busy, load, add, shift, inbit;

  logic [1:0] req2;
  logic       sign2;
  logic [1:0] grant2, done2, sel2;
  logic       busy2, load2, add2, shift2, inbit2;

  always #5 clk = ~clk;

  div_sequencer #(.WIDTH(W)) dut (
    .clk(clk), .reset(reset), .req(req), .sign(sign),
    .grant(grant), .done(done), .busy(busy), .load(load), .add(add),
    .shift(shift), .inbit(inbit), .sel(sel)
  );

  div_sequencer #(.WIDTH(2)) dut2 (
    .clk(clk), .reset(reset), .req(req2), .sign(sign2),
    .grant(grant2), .done(done2), .busy(busy2), .load(load2), .add(add2),
    .shift(shift2), .inbit(inbit2), .sel(sel2)
  );

  int checks   = 0;
  int failures = 0;
  int cyc      = 0;

  // Operation-level model: an op is LOAD, W x (TEST, RESTORE|ACCEPT), DONE.
  bit         m_active;
  logic [1:0] m_owner;
  int         m_pos;
  int         m_fav;
  int         sign_pat;
  bit         m_signs [W];

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=0x%0h exp=0x%0h", tag, got, exp);
    end
  endtask

  function automatic logic [10:0] dut_vec();
    return {grant, done, busy, load, add, shift, inbit, sel};
  endfunction

  function automatic logic [10:0] dut2_vec();
    return {grant2, done2, busy2, load2, add2, shift2, inbit2, sel2};
  endfunction

  function automatic logic [10:0] m_expect();
    logic [5:0] c;
    if (!m_active) return 11'b0;
    if (m_pos == 0)            c = C_LOAD;
    else if (m_pos == LAST)    c = C_IDLE;
    else if (m_pos % 2 == 1)   c = C_TEST;
    else                       c = m_signs[(m_pos - 2) / 2] ? C_REST : C_ACC;
    return {m_owner, (m_pos == LAST) ? m_owner : 2'b00, 1'b1, c};
  endfunction

  task automatic model_reset();
    m_active = 1'b0;
    m_owner  = 2'b00;
    m_pos    = 0;
    m_fav    = 0;
  endtask

  task automatic model_step(input logic [1:0] r);
    logic [1:0] elig;
    int win;
    if (m_active && m_pos < LAST) begin
      m_pos++;
    end else begin
      elig = m_active ? (r & ~m_owner) : r;
      if (elig != 2'b00) begin
        win      = (elig == 2'b11) ? m_fav : ((elig == 2'b10) ? 1 : 0);
        m_owner  = 2'b01 << win;
        m_fav    = 1 - win;
        m_active = 1'b1;
        m_pos    = 0;
        for (int i = 0; i < W; i++)
          m_signs[i] = (sign_pat == 1) ? 1'b0 : (sign_pat == 2) ? (i % 2 == 0) : 1'($urandom);
      end else begin
        m_active = 1'b0;
        m_owner  = 2'b00;
      end
    end
  endtask

  // Called at a negedge: check this cycle, drive the next edge, advance model.
  task automatic cycle(input logic [1:0] r);
    check($sformatf("out@%0d", cyc), 32'(dut_vec()), 32'(m_expect()));
    req = r;
    if (m_active && (m_pos % 2 == 1) && m_pos < LAST) sign = m_signs[(m_pos - 1) / 2];
    else sign = 1'($urandom);
    model_step(r);
    @(negedge clk);
    cyc++;
  endtask

  task automatic hold_op(input logic [1:0] r, input string tag);
    int n;
    n = 0;
    do begin
      cycle(r);
      n++;
    end while (done == 2'b00 && n < 40);
    check({tag, "_lat"}, 32'(n), 32'(2 * W + 2));
    cycle(r);
  endtask

  task automatic drain(input string tag);
    int n;
    n = 0;
    while ((m_active || busy) && n < 60) begin
      cycle(2'b00);
      n++;
    end
    check({tag, "_idle"}, 32'(busy), 32'(0));
  endtask

  logic [1:0]  t3_exp [3];
  logic [10:0] t2_exp [7];
  logic        t2_sgn [7];

  initial begin
    int k;
    int n;
    t3_exp = '{2'b01, 2'b10, 2'b01};
    t2_exp = '{{2'b01, 2'b00, 1'b1, C_LOAD}, {2'b01, 2'b00, 1'b1, C_TEST},
               {2'b01, 2'b00, 1'b1, C_REST}, {2'b01, 2'b00, 1'b1, C_TEST},
               {2'b01, 2'b00, 1'b1, C_ACC},  {2'b01, 2'b01, 1'b1, C_IDLE},
               11'b0};
    t2_sgn = '{1'b1, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0};

    reset = 1'b0; req = 2'b00; sign = 1'b0; req2 = 2'b00; sign2 = 1'b0;
    sign_pat = 0;
    model_reset();
    repeat (3) @(negedge clk);
    check("rst_vec", 32'(dut_vec()), 32'(0));
    check("rst_vec2", 32'(dut2_vec()), 32'(0));
    reset = 1'b1;
    @(negedge clk);

    // Tie straight after reset goes to requester 0.
    cycle(2'b11);
    check("t0_grant", 32'(grant), 32'(2'b01));
    drain("t0");

    sign_pat = 1;
    hold_op(2'b01, "t1");
    cycle(2'b00);

    sign_pat = 2;
    hold_op(2'b10, "t2");
    cycle(2'b00);

    // Both requesters held high: alternating grants, no idle cycle between ops.
    sign_pat = 0;
    k = 0;
    for (int i = 0; i < 3 * (2 * W + 2); i++) begin
      cycle(2'b11);
      if (done != 2'b00) begin
        if (k < 3) check($sformatf("t3_done%0d", k), 32'(done), 32'(t3_exp[k]));
        k++;
      end
    end
    check("t3_ndone", 32'(k), 32'(3));
    cycle(2'b00);
    drain("t3");

    // Reset in the middle of an operation.
    cycle(2'b01);
    repeat (6) cycle(2'b01);
    reset = 1'b0;
    #1;
    check("t4_async", 32'(dut_vec()), 32'(0));
    model_reset();
    @(negedge clk);
    cycle(2'b00);
    reset = 1'b1;
    cycle(2'b00);
    cycle(2'b11);
    check("t4_ptr", 32'(grant), 32'(2'b01));
    drain("t4a");
    hold_op(2'b10, "t4");
    cycle(2'b00);

    // Request dropped after one cycle still completes.
    cycle(2'b01);
    n = 1;
    while (done == 2'b00 && n < 40) begin
      cycle(2'b00);
      n++;
    end
    check("t5_lat", 32'(n), 32'(2 * W + 2));
    drain("t5");

    sign_pat = 0;
    for (int i = 0; i < 800; i++) cycle(2'($urandom));
    drain("rand");

    // WIDTH=2 instance against a fixed trace.
    req2 = 2'b01;
    cycle(2'b00);
    req2 = 2'b00;
    for (int i = 0; i < 7; i++) begin
      check($sformatf("w2_%0d", i), 32'(dut2_vec()), 32'(t2_exp[i]));
      sign2 = t2_sgn[i];
      cycle(2'b00);
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog timeout checks=%0d", checks);
    $fatal(1, "watchdog");
  end

endmodule
